convolve_fpga_mac_accum: RTL and testbench
==========================================

// Module: convolve_fpga_mac_accum
// PURPOSE
//  Consumes the signed 16-bit tap products from the convolve_fpga 16s x 8ns multiplier (4-stage, ce-gated) and
//  accumulates one window of TAPS products into one output pixel.
//  It rounds, right-shifts and clamps each sum to an unsigned OUT_W-bit pixel.
//  It drives the shared ce back to the multiplier pipeline, so output backpressure freezes every upstream stage.
// PARAMETERS
//  ACC_W  24  accumulator width in bits; sum is signed; must be >= 16 + clog2(TAPS)
//  TAPS    9  products per window (3x3 kernel); valid range 1..255
//  SHIFT   4  right shift applied to the sum (kernel normalisation); valid range 0..ACC_W-2
//  OUT_W   8  output pixel width in bits; output is unsigned
// PORTS
//  ap_clk      in   1      single clock; all logic is rising-edge
//  ap_rst_n    in   1      asynchronous active-low reset
//  prod_data   in   16     signed product, time-aligned with prod_valid
//  prod_valid  in   1      prod_data is valid this cycle; consumed only when ce=1
//  prod_last   in   1      final product of the current window; qualified by prod_valid
//  ce          out  1      pipeline enable to the multiplier and upstream stages
//  out_data    out  OUT_W  clamped pixel
//  out_valid   out  1      out_data is valid
//  out_ready   in   1      consumer accepts out_data
//  tap_err     out  1      sticky flag: a window closed with a tap count other than TAPS
// BEHAVIOUR
//  Reset (async assert, sync release): acc=0, tap_cnt=0, state=FIRST, out_valid=0, out_data=0, tap_err=0.
//   ce=1 while reset is asserted (out_valid=0).
//  ce = !out_valid | out_ready. This is combinational and contains no other term.
//  Accept condition: acc_en = prod_valid & ce. Inputs are ignored when acc_en=0; all state holds.
//  Product extension: prod_data is sign-extended to ACC_W bits.
//  Accumulation wraps at ACC_W bits and does not saturate; the parameter constraint guarantees no overflow.
//  FSM, 2 states:
//   FIRST : acc_en & !last -> acc=prod, tap_cnt=1, go to ACC.
//           acc_en & last  -> single-tap window: sum=prod, emit (below), stay in FIRST.
//   ACC   : acc_en & !last -> acc+=prod, tap_cnt++ (saturates at 255).
//           acc_en & last  -> sum=acc+prod, emit, tap_cnt=0, go to FIRST.
//  Emit, in the cycle after the closing acc_en:
//   - r = sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0), arithmetic shift right by SHIFT (round half up).
//   - r<0 -> 0; r>2^OUT_W-1 -> 2^OUT_W-1; otherwise r[OUT_W-1:0].
//   - out_data <= result; out_valid <= 1.
//  Latency: closing product accepted in cycle N -> out_valid=1 in cycle N+1.
//  Output register: out_valid clears on out_valid & out_ready unless a new emit occurs in the same cycle.
//   On a simultaneous handshake and emit, out_valid stays 1 and out_data takes the new value. No bubble.
//  Stall: out_valid=1 & out_ready=0 -> ce=0. No product is consumed and out_data/out_valid are held stable.
//  tap_err: set when a window closes with (tap_cnt+1) != TAPS.
//   The pixel is still emitted. tap_err clears only on reset.
//  prod_last without prod_valid has no effect.
//  Reset mid-window discards the partial sum; the next accepted product starts a new window.
// TESTING
//  1. TAPS=9, SHIFT=4, nine products of 16, last on 9th -> out_data=9 ((144+8)>>4), out_valid 1 cycle later, tap_err=0.
//  2. Nine products of -100 -> sum -900 -> clamp out_data=0.
//     Nine products of 2000 -> sum 18000 -> clamp out_data=255.
//  3. Hold out_ready=0 with out_valid=1 for 5 cycles while prod_valid=1 ->
//     ce=0 for all 5 cycles; out_data stable; sum of the next window is unaffected.
//  4. Back-to-back windows with out_ready=1: out_valid is continuously 1 across window boundaries
//     and every pixel is delivered exactly once.
//  5. prod_last on 7th product -> pixel emitted, tap_err=1 and stays 1; next 9-tap window is correct.
//  6. Assert ap_rst_n=0 after 4 products -> out_valid=0 and tap_err=0 immediately (async);
//     after release, a fresh 9 x 16 window yields 9.

Source files
------------

// File: rtl/convolve_fpga_mac_accum.sv
// convolve_fpga_mac_accum
//   Accumulates one window of TAPS signed 16-bit tap products from the
//   multiplier pipeline into a single output pixel. Each finished sum is
//   rounded (half up), arithmetically shifted right by SHIFT and clamped to an
//   unsigned OUT_W-bit pixel. The shared pipeline enable ce is driven back
//   upstream, so a stalled consumer freezes the whole multiplier chain.
//
// Ports
//   ap_clk      in   1      rising-edge clock
//   ap_rst_n    in   1      active-low reset, asserted asynchronously, released synchronously
//   prod_data   in   16     signed tap product
//   prod_valid  in   1      prod_data valid (consumed only when ce=1)
//   prod_last   in   1      closing product of the window, qualified by prod_valid
//   ce          out  1      pipeline enable to the multiplier and upstream stages
//   out_data    out  OUT_W  clamped pixel
//   out_valid   out  1      out_data valid
//   out_ready   in   1      consumer accepts out_data
//   tap_err     out  1      sticky: a window closed with a tap count other than TAPS
module convolve_fpga_mac_accum #(
  parameter int ACC_W = 24,
  parameter int TAPS  = 9,
  parameter int SHIFT = 4,
  parameter int OUT_W = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [15:0]      prod_data,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             ce,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             tap_err
);

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_ACC   = 1'b1
  } state_t;

  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;

  // Round half up, arithmetic shift, clamp to [0, 2^OUT_W-1]. One guard bit
  // keeps the rounding add from wrapping at the top of the accumulator range.
  function automatic logic [OUT_W-1:0] round_clamp(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    t = {s[ACC_W-1], s};
    t = t + RND;
    t = t >>> SHIFT;
    if (t[ACC_W])
      round_clamp = '0;
    else if (|t[ACC_W-1:OUT_W])
      round_clamp = '1;
    else
      round_clamp = t[OUT_W-1:0];
  endfunction

  // Reset synchronizer: assertion propagates immediately, release lands on a
  // clock edge so no flop sees reset removal near its capture window.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  state_t                   r_state, w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc_p0;
  logic [7:0]               r_tap_cnt_p0;
  logic [OUT_W-1:0]         r_out_data_p1;
  logic                     r_out_valid_p1;
  logic                     r_tap_err;

  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_acc_en;
  logic                     w_emit;
  logic                     w_bad_cnt;
  logic [8:0]               w_cnt_close;
  logic [7:0]               w_cnt_inc;
  logic [OUT_W-1:0]         w_pix;

  // Backpressure: the only stall source is a held, unaccepted output.
  assign ce       = !r_out_valid_p1 | out_ready;
  assign w_acc_en = prod_valid & ce;
  assign w_prod   = signed'(prod_data);

  always_comb begin
    w_state_nxt = r_state;
    w_ext       = {{(ACC_W-16){w_prod[15]}}, w_prod};
    w_sum       = (r_state == ST_FIRST) ? w_ext : r_acc_p0 + w_ext;
    w_emit      = w_acc_en & prod_last;
    w_cnt_close = {1'b0, r_tap_cnt_p0} + 9'd1;
    w_bad_cnt   = (w_cnt_close != 9'(TAPS));
    w_pix       = round_clamp(w_sum);
    if (r_state == ST_FIRST)
      w_cnt_inc = 8'd1;
    else if (r_tap_cnt_p0 == 8'hFF)
      w_cnt_inc = r_tap_cnt_p0;
    else
      w_cnt_inc = r_tap_cnt_p0 + 8'd1;
    if (w_acc_en)
      w_state_nxt = prod_last ? ST_FIRST : ST_ACC;
  end

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_FIRST;
    else          r_state <= w_state_nxt;
  end

  // Stage p0: window accumulation
  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_acc_p0     <= '0;
      r_tap_cnt_p0 <= '0;
    end else if (w_acc_en) begin
      if (prod_last) begin
        r_acc_p0     <= '0;
        r_tap_cnt_p0 <= '0;
      end else begin
        r_acc_p0     <= w_sum;
        r_tap_cnt_p0 <= w_cnt_inc;
      end
    end
  end

  // Stage p1: output register; a new emit wins over the handshake clear so
  // back-to-back pixels flow without a bubble.
  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_data_p1  <= '0;
      r_out_valid_p1 <= 1'b0;
      r_tap_err      <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_data_p1  <= w_pix;
        r_out_valid_p1 <= 1'b1;
      end else if (r_out_valid_p1 & out_ready) begin
        r_out_valid_p1 <= 1'b0;
      end
      if (w_emit & w_bad_cnt)
        r_tap_err <= 1'b1;
    end
  end

  assign out_data  = r_out_data_p1;
  assign out_valid = r_out_valid_p1;
  assign tap_err   = r_tap_err;

endmodule

// File: tb/tb_convolve_fpga_mac_accum.sv
module tb_convolve_fpga_mac_accum;
  localparam int ACC_W = 24;
  localparam int TAPS  = 9;
  localparam int SHIFT = 4;
  localparam int OUT_W = 8;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [15:0]      prod_data;
  logic             prod_valid;
  logic             prod_last;
  logic             ce;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             tap_err;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int mon_exp;

  convolve_fpga_mac_accum #(
    .ACC_W(ACC_W), .TAPS(TAPS), .SHIFT(SHIFT), .OUT_W(OUT_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_last (prod_last),
    .ce        (ce),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tap_err   (tap_err)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference pixel: round half up, shift, clamp.
  function automatic int exp_pix(input int s);
    int r;
    r = (s + (1 << (SHIFT - 1))) >>> SHIFT;
    if (r < 0) return 0;
    if (r > (2**OUT_W - 1)) return 2**OUT_W - 1;
    return r;
  endfunction

  // Scoreboard: every handshake pops one expected pixel.
  always @(negedge ap_clk) begin
    if (ap_rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pixel %0d, expected no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== 8'(mon_exp)) begin
          n_fail++;
          $display("FAIL sb_pixel: got %0d, expected %0d", out_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic send_one(input int d, input bit last);
    int  n;
    bit  took;
    prod_data  = 16'(d);
    prod_valid = 1'b1;
    prod_last  = last;
    n = 0;
    forever begin
      @(negedge ap_clk);
      took = ce;
      @(posedge ap_clk);
      #1;
      if (took) break;
      n++;
      if (n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: ce=%0b, required 1", ce);
        break;
      end
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic send_window(input int n, input int v);
    for (int i = 1; i <= n; i++) send_one(v, i == n);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge ap_clk);
      n++;
    end
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d pixels outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    ap_rst_n   = 1'b0;
    prod_data  = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || tap_err !== 1'b0 || ce !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b data=%0d err=%0b ce=%0b, required 0 0 0 1",
               out_valid, out_data, tap_err, ce);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    exp_q.push_back(9);
    for (int i = 0; i < 8; i++) send_one(16, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: out_valid=%0b, required 0", out_valid);
    end
    send_one(16, 1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'd9) begin
      n_fail++;
      $display("FAIL basic_latency: valid=%0b data=%0d, required 1 9", out_valid, out_data);
    end
    n_tests++;
    if (tap_err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_tap_err: got %0b, required 0", tap_err);
    end
    drain("basic");
  endtask

  task automatic test_clamp;
    out_ready = 1'b1;
    exp_q.push_back(0);
    send_window(9, -100);
    exp_q.push_back(255);
    send_window(9, 2000);
    drain("clamp");
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    exp_q.push_back(9);
    send_window(9, 16);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_valid: out_valid=%0b, required 1", out_valid);
    end
    prod_data  = 16'd16;
    prod_valid = 1'b1;
    prod_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      n_tests++;
      if (ce !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ce cycle %0d: ce=%0b, required 0", i, ce);
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'd9) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: valid=%0b data=%0d, required 1 9", i, out_valid, out_data);
      end
      @(posedge ap_clk);
      #1;
    end
    out_ready = 1'b1;
    exp_q.push_back(9);
    @(posedge ap_clk);
    #1;
    prod_valid = 1'b0;
    for (int i = 0; i < 7; i++) send_one(16, 1'b0);
    send_one(16, 1'b1);
    drain("stall");
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    exp_q.push_back(exp_pix(450));
    for (int i = 1; i <= 9; i++) send_one(10 * i, i == 9);
    exp_q.push_back(exp_pix(-63));
    send_window(9, -7);
    exp_q.push_back(exp_pix(2700));
    send_window(9, 300);
    drain("b2b");
  endtask

  task automatic test_tap_err;
    int vals[4] = '{48, 160, -5, 4000};
    int exps[4] = '{3, 10, 0, 250};
    out_ready = 1'b1;
    exp_q.push_back(7);
    send_window(7, 16);
    n_tests++;
    if (tap_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_err_set: got %0b, required 1", tap_err);
    end
    // Single-tap windows back to back: output must stay valid every cycle.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      send_one(vals[i], 1'b1);
      n_tests++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_continuous %0d: out_valid=%0b, required 1", i, out_valid);
      end
    end
    exp_q.push_back(9);
    send_window(9, 16);
    n_tests++;
    if (tap_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tap_err_sticky: got %0b, required 1", tap_err);
    end
    drain("tap_err");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_one(1000, 1'b0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || tap_err !== 1'b0 || ce !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: valid=%0b err=%0b ce=%0b, required 0 0 1", out_valid, tap_err, ce);
    end
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    exp_q.push_back(9);
    send_window(9, 16);
    n_tests++;
    if (tap_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tap_err: got %0b, required 0", tap_err);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stall();
    test_back_to_back();
    test_tap_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
